program_loader: RTL and testbench

Upstream stage of the CPU: streams the compiled program image byte-by-byte from the SD-card reader into the 8 MB byte-addressed SDRAM, starting at address 0. While loading, it finds the first code-section marker byte (14) and reports the address after it as the code section start. The CPU stays in its load-to-RAM state until `done`, then sets IP from `code_start_addr`.

---
 rtl/program_loader_pkg.sv | 28 ++
 rtl/program_loader.sv | 156 +++++++++++++++
 tb/tb_program_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared loader definitions: state encodings, error codes and the code-section marker.
// The CPU imports the same marker constant so both sides agree on the image format.
package program_loader_pkg;

  typedef enum logic [2:0] {
    LOADER_STATE_IDLE  = 3'd0,
    LOADER_STATE_LOAD  = 3'd1,
    LOADER_STATE_FLUSH = 3'd2,
    LOADER_STATE_DONE  = 3'd3,
    LOADER_STATE_ERROR = 3'd4
  } loader_state_t;

  localparam logic [1:0] LOADER_ERR_NONE       = 2'd0;
  localparam logic [1:0] LOADER_ERR_NO_MARKER  = 2'd1;
  localparam logic [1:0] LOADER_ERR_OVERFLOW   = 2'd2;
  localparam logic [1:0] LOADER_ERR_EMPTY_CODE = 2'd3;

  localparam logic [7:0] CODE_SECTION_MARKER = 8'd14;

  function automatic logic loader_is_busy(input loader_state_t s);
    return (s == LOADER_STATE_LOAD) || (s == LOADER_STATE_FLUSH);
  endfunction

  function automatic logic loader_accepts_start(input loader_state_t s);
    return (s == LOADER_STATE_IDLE) || (s == LOADER_STATE_DONE) || (s == LOADER_STATE_ERROR);
  endfunction

endpackage

// File: rtl/program_loader.sv
// Streams the program image into SDRAM from address 0 and locates the first
// code-section marker; reports the address after it as the code start.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH        = 23,
  parameter int         MAX_BYTES         = 8000000,
  parameter logic [7:0] MARKER            = CODE_SECTION_MARKER,
  parameter int         OPERAND_SIZE_BITS = 32
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         start,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic                         mem_wr_en,
  output logic [ADDR_WIDTH-1:0]        mem_wr_addr,
  output logic [7:0]                   mem_wr_data,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [1:0]                   error_code,
  output logic [OPERAND_SIZE_BITS-1:0] code_start_addr,
  output logic [ADDR_WIDTH-1:0]        byte_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_BYTES - 1);

  loader_state_t                  r_state;
  loader_state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]          r_count;
  logic [ADDR_WIDTH-1:0]          w_count_inc;
  logic                           r_found;
  logic [OPERAND_SIZE_BITS-1:0]   r_code_start;
  logic [1:0]                     r_err_code;
  logic [1:0]                     w_err_code_next;
  logic                           r_done;
  logic                           w_done_next;
  logic                           r_error;
  logic                           w_error_next;
  logic                           r_wr_en;
  logic [ADDR_WIDTH-1:0]          r_wr_addr;
  logic [7:0]                     r_wr_data;
  logic                           w_in_ready;
  logic                           w_accept;
  logic                           w_start_load;
  logic                           w_first_marker;

  assign w_in_ready     = (r_state == LOADER_STATE_LOAD);
  assign w_accept       = in_valid && w_in_ready;
  assign w_start_load   = start && loader_accepts_start(r_state);
  assign w_count_inc    = r_count + 1'b1;
  assign w_first_marker = w_accept && (in_data == MARKER) && !r_found;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= LOADER_STATE_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Status outputs are resolved here and registered alongside the state.
  always_comb begin
    w_state_next    = r_state;
    w_err_code_next = r_err_code;
    w_done_next     = r_done;
    w_error_next    = r_error;
    case (r_state)
      LOADER_STATE_IDLE, LOADER_STATE_DONE, LOADER_STATE_ERROR: begin
        if (start) begin
          w_state_next    = LOADER_STATE_LOAD;
          w_err_code_next = LOADER_ERR_NONE;
          w_done_next     = 1'b0;
          w_error_next    = 1'b0;
        end
      end
      LOADER_STATE_LOAD: begin
        if (w_accept) begin
          if (in_last) begin
            w_state_next = LOADER_STATE_FLUSH;
          end else if (r_count == LAST_ADDR) begin
            w_state_next    = LOADER_STATE_ERROR;
            w_err_code_next = LOADER_ERR_OVERFLOW;
            w_error_next    = 1'b1;
          end
        end
      end
      LOADER_STATE_FLUSH: begin
        if (!r_found) begin
          w_state_next    = LOADER_STATE_ERROR;
          w_err_code_next = LOADER_ERR_NO_MARKER;
          w_error_next    = 1'b1;
        end else if (r_code_start >= OPERAND_SIZE_BITS'(r_count)) begin
          // Marker was the final byte, so there is no code after it.
          w_state_next    = LOADER_STATE_ERROR;
          w_err_code_next = LOADER_ERR_EMPTY_CODE;
          w_error_next    = 1'b1;
        end else begin
          w_state_next = LOADER_STATE_DONE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = LOADER_STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_count      <= '0;
      r_found      <= 1'b0;
      r_code_start <= '0;
      r_err_code   <= LOADER_ERR_NONE;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_err_code <= w_err_code_next;
      r_done     <= w_done_next;
      r_error    <= w_error_next;
      r_wr_en    <= w_accept;
      if (w_accept) begin
        r_wr_addr <= r_count;
        r_wr_data <= in_data;
        r_count   <= w_count_inc;
      end
      if (w_first_marker) begin
        r_found      <= 1'b1;
        r_code_start <= OPERAND_SIZE_BITS'(w_count_inc);
      end
      if (w_start_load) begin
        r_count      <= '0;
        r_found      <= 1'b0;
        r_code_start <= '0;
      end
    end
  end

  assign in_ready        = w_in_ready;
  assign busy            = loader_is_busy(r_state);
  assign mem_wr_en       = r_wr_en;
  assign mem_wr_addr     = r_wr_addr;
  assign mem_wr_data     = r_wr_data;
  assign done            = r_done;
  assign error           = r_error;
  assign error_code      = r_err_code;
  assign code_start_addr = r_code_start;
  assign byte_count      = r_count;

endmodule

// File: tb/tb_program_loader.sv
// Randomised and directed bench for program_loader; a full-size instance plus a
// 4-byte-capacity instance for the overflow path, both checked against a queue model.
module tb_program_loader;

  typedef logic [7:0] byte_q_t[$];

  logic        clk;
  logic        reset;
  int          cyc;
  int          n_checks;
  int          n_pass;

  // full-size instance
  logic        start, in_valid, in_last;
  logic [7:0]  in_data;
  logic        in_ready, mem_wr_en, busy, done, error;
  logic [22:0] mem_wr_addr, byte_count;
  logic [7:0]  mem_wr_data;
  logic [1:0]  error_code;
  logic [31:0] code_start_addr;

  // small instance
  logic        s_start, s_in_valid, s_in_last;
  logic [7:0]  s_in_data;
  logic        s_in_ready, s_mem_wr_en, s_busy, s_done, s_error;
  logic [22:0] s_mem_wr_addr, s_byte_count;
  logic [7:0]  s_mem_wr_data;
  logic [1:0]  s_error_code;
  logic [31:0] s_code_start_addr;

  logic [22:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          wr_cyc_q[$];
  logic [22:0] s_wr_addr_q[$];

  program_loader dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .error(error), .error_code(error_code),
    .code_start_addr(code_start_addr), .byte_count(byte_count)
  );

  program_loader #(.MAX_BYTES(4)) dut_small (
    .CLOCK_50(clk), .reset(reset), .start(s_start), .in_data(s_in_data),
    .in_valid(s_in_valid), .in_last(s_in_last), .in_ready(s_in_ready),
    .mem_wr_en(s_mem_wr_en), .mem_wr_addr(s_mem_wr_addr), .mem_wr_data(s_mem_wr_data),
    .busy(s_busy), .done(s_done), .error(s_error), .error_code(s_error_code),
    .code_start_addr(s_code_start_addr), .byte_count(s_byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      wr_addr_q.push_back(mem_wr_addr);
      wr_data_q.push_back(mem_wr_data);
      wr_cyc_q.push_back(cyc);
    end
    if (s_mem_wr_en === 1'b1) s_wr_addr_q.push_back(s_mem_wr_addr);
  end

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", mem_wr_en); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0 || error !== 1'b0) $display("FAIL reset_flags got done=%b error=%b want 0/0", done, error); else n_pass++;
    n_checks++; if (error_code !== 2'd0) $display("FAIL reset_error_code got %0d want 0", error_code); else n_pass++;
    n_checks++; if (code_start_addr !== 32'd0) $display("FAIL reset_code_start got %0d want 0", code_start_addr); else n_pass++;
    n_checks++; if (byte_count !== 23'd0) $display("FAIL reset_byte_count got %0d want 0", byte_count); else n_pass++;
    n_checks++; if (in_ready !== 1'b0 || mem_wr_addr !== 23'd0) $display("FAIL reset_ready_addr got ready=%b addr=%0d want 0/0", in_ready, mem_wr_addr); else n_pass++;
    reset = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h0E;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0) $display("FAIL idle_ready got ready=%b busy=%b want 0/0", in_ready, busy); else n_pass++;
    n_checks++; if (wr_addr_q.size() !== 0) $display("FAIL idle_no_write got %0d writes want 0", wr_addr_q.size()); else n_pass++;
  endtask

  // Streams one image into the full-size loader and compares against the model.
  task automatic run_stream(input string name, input byte_q_t b, input bit rand_valid);
    int n;
    int i;
    int budget;
    int marker_idx;
    logic [1:0]  exp_code;
    logic [31:0] exp_cs;
    n = b.size();
    marker_idx = -1;
    for (int k = 0; k < n; k++) if (marker_idx < 0 && b[k] == 8'd14) marker_idx = k;
    if (marker_idx < 0) begin
      exp_code = 2'd1; exp_cs = 32'd0;
    end else begin
      exp_cs = 32'(marker_idx + 1);
      exp_code = (marker_idx + 1 >= n) ? 2'd3 : 2'd0;
    end

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) $display("FAIL %s start_load got busy=%b ready=%b want 1/1", name, busy, in_ready); else n_pass++;
    n_checks++; if (done !== 1'b0 || error !== 1'b0 || byte_count !== 23'd0) $display("FAIL %s start_clear got done=%b error=%b count=%0d want 0/0/0", name, done, error, byte_count); else n_pass++;

    i = 0; budget = 0;
    while (i < n && budget < 300) begin
      in_valid = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
      start    = rand_valid && ($urandom_range(0, 5) == 0);
      in_data  = b[i];
      in_last  = (i == n - 1);
      @(negedge clk);
      if (in_valid) i++;
      budget++;
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    if (i < n) begin
      n_checks++;
      $display("FAIL %s timeout got %0d bytes accepted want %0d", name, i, n);
      return;
    end

    n_checks++; if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) $display("FAIL %s flush got busy=%b done=%b error=%b want 1/0/0", name, busy, done, error); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== (exp_code == 2'd0)) $display("FAIL %s done got %b want %b", name, done, exp_code == 2'd0); else n_pass++;
    n_checks++; if (error !== (exp_code != 2'd0)) $display("FAIL %s error got %b want %b", name, error, exp_code != 2'd0); else n_pass++;
    n_checks++; if (error_code !== exp_code) $display("FAIL %s error_code got %0d want %0d", name, error_code, exp_code); else n_pass++;
    n_checks++; if (code_start_addr !== exp_cs) $display("FAIL %s code_start got %0d want %0d", name, code_start_addr, exp_cs); else n_pass++;
    n_checks++; if (byte_count !== 23'(n)) $display("FAIL %s byte_count got %0d want %0d", name, byte_count, n); else n_pass++;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || mem_wr_en !== 1'b0) $display("FAIL %s idle_after got busy=%b ready=%b wr=%b want 0/0/0", name, busy, in_ready, mem_wr_en); else n_pass++;
    n_checks++;
    if (wr_addr_q.size() != n) begin
      $display("FAIL %s write_count got %0d want %0d", name, wr_addr_q.size(), n);
    end else begin
      n_pass++;
      for (int k = 0; k < n; k++) begin
        n_checks++;
        if (wr_addr_q[k] !== 23'(k) || wr_data_q[k] !== b[k])
          $display("FAIL %s write%0d got addr=%0d data=%h want addr=%0d data=%h", name, k, wr_addr_q[k], wr_data_q[k], k, b[k]);
        else n_pass++;
        if (!rand_valid && k > 0) begin
          n_checks++;
          if (wr_cyc_q[k] != wr_cyc_q[k-1] + 1) $display("FAIL %s b2b%0d got gap=%0d want 1", name, k, wr_cyc_q[k] - wr_cyc_q[k-1]); else n_pass++;
        end
      end
    end
    $display("stream %s: %0d bytes, done=%b error=%b code=%0d cs=%0d", name, n, done, error, error_code, code_start_addr);
  endtask

  task automatic test_directed;
    byte_q_t q;
    q = {8'h05, 8'h0E, 8'h01, 8'h02}; run_stream("plan_basic", q, 1'b0);
    q = {8'h0E, 8'h0E, 8'h07};        run_stream("plan_double_marker", q, 1'b0);
    q = {8'h01, 8'h02};               run_stream("plan_no_marker", q, 1'b0);
    q = {8'h03, 8'h0E};               run_stream("plan_empty_code", q, 1'b0);
    q = {8'h0E};                      run_stream("single_marker", q, 1'b0);
  endtask

  task automatic test_random;
    byte_q_t q;
    int n;
    for (int t = 0; t < 16; t++) begin
      q.delete();
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++)
        q.push_back(($urandom_range(0, 3) == 0) ? 8'h0E : 8'($urandom_range(0, 255)));
      run_stream($sformatf("rand%0d", t), q, t[0]);
    end
  endtask

  task automatic test_reset_mid_load;
    byte_q_t q;
    int i;
    int k;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    i = 0; k = 0;
    while (i < 3 && k < 50) begin
      in_valid = (k % 2 == 0);
      in_data  = 8'(8'h20 + i);
      in_last  = 1'b0;
      @(negedge clk);
      if (in_valid) i++;
      k++;
    end
    in_valid = 1'b0;
    n_checks++; if (mem_wr_en !== 1'b1) $display("FAIL midreset_pre_wr got %b want 1", mem_wr_en); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (mem_wr_en !== 1'b0) $display("FAIL midreset_wr_en got %b want 0", mem_wr_en); else n_pass++;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL midreset_state got busy=%b ready=%b want 0/0", busy, in_ready); else n_pass++;
    n_checks++; if (byte_count !== 23'd0) $display("FAIL midreset_count got %0d want 0", byte_count); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    $display("reset mid-load after %0d bytes", i);
    q = {8'h11, 8'h22, 8'h0E, 8'h33, 8'h44};
    run_stream("reload_after_reset", q, 1'b0);
  endtask

  task automatic test_overflow;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    s_wr_addr_q.delete();
    for (int j = 0; j < 5; j++) begin
      s_in_valid = 1'b1;
      s_in_data  = 8'($urandom_range(0, 13));
      s_in_last  = 1'b0;
      @(negedge clk);
      if (j < 3) begin
        n_checks++; if (s_in_ready !== 1'b1 || s_error !== 1'b0) $display("FAIL ovf_loading%0d got ready=%b error=%b want 1/0", j, s_in_ready, s_error); else n_pass++;
      end else if (j == 3) begin
        n_checks++; if (s_in_ready !== 1'b0) $display("FAIL ovf_ready got %b want 0", s_in_ready); else n_pass++;
        n_checks++; if (s_error !== 1'b1 || s_done !== 1'b0) $display("FAIL ovf_flags got error=%b done=%b want 1/0", s_error, s_done); else n_pass++;
        n_checks++; if (s_error_code !== 2'd2) $display("FAIL ovf_code got %0d want 2", s_error_code); else n_pass++;
      end else begin
        n_checks++; if (s_mem_wr_en !== 1'b0) $display("FAIL ovf_fifth_write got %b want 0", s_mem_wr_en); else n_pass++;
      end
    end
    s_in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (s_wr_addr_q.size() != 4) $display("FAIL ovf_write_count got %0d want 4", s_wr_addr_q.size()); else n_pass++;
    n_checks++; if (s_byte_count !== 23'd4 || s_busy !== 1'b0) $display("FAIL ovf_final got count=%0d busy=%b want 4/0", s_byte_count, s_busy); else n_pass++;
    if (s_wr_addr_q.size() == 4) begin
      n_checks++; if (s_wr_addr_q[3] !== 23'd3) $display("FAIL ovf_last_addr got %0d want 3", s_wr_addr_q[3]); else n_pass++;
    end
    $display("overflow: %0d writes, error_code=%0d", s_wr_addr_q.size(), s_error_code);
  endtask

  task automatic test_exact_fit;
    logic [7:0] pat[4];
    pat = '{8'h01, 8'h0E, 8'h02, 8'h03};
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      s_in_valid = 1'b1;
      s_in_data  = pat[j];
      s_in_last  = (j == 3);
      @(negedge clk);
    end
    s_in_valid = 1'b0; s_in_last = 1'b0;
    n_checks++; if (s_busy !== 1'b1 || s_error !== 1'b0) $display("FAIL fit_flush got busy=%b error=%b want 1/0", s_busy, s_error); else n_pass++;
    @(negedge clk);
    n_checks++; if (s_done !== 1'b1 || s_error_code !== 2'd0) $display("FAIL fit_done got done=%b code=%0d want 1/0", s_done, s_error_code); else n_pass++;
    n_checks++; if (s_code_start_addr !== 32'd2) $display("FAIL fit_code_start got %0d want 2", s_code_start_addr); else n_pass++;
    $display("exact fit: done=%b code_start=%0d", s_done, s_code_start_addr);
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_pass = 0;
    reset = 1'b1;
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0; s_in_data = 8'h00;
    repeat (2) @(negedge clk);
    test_reset;
    test_directed;
    test_random;
    test_reset_mid_load;
    test_overflow;
    test_exact_fit;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
